// File: rtl/axi4lite_arb.sv
// Two-master AXI4-Lite arbiter: round-robin grant, one outstanding transaction
// on the master port, combinational forwarding of the granted requester.
module axi4lite_arb #(
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              inport0_awvalid_i,
  input  logic [ADDR_W-1:0] inport0_awaddr_i,
  input  logic              inport0_wvalid_i,
  input  logic [31:0]       inport0_wdata_i,
  input  logic [3:0]        inport0_wstrb_i,
  input  logic              inport0_bready_i,
  input  logic              inport0_arvalid_i,
  input  logic [ADDR_W-1:0] inport0_araddr_i,
  input  logic              inport0_rready_i,
  output logic              inport0_awready_o,
  output logic              inport0_wready_o,
  output logic              inport0_bvalid_o,
  output logic [1:0]        inport0_bresp_o,
  output logic              inport0_arready_o,
  output logic              inport0_rvalid_o,
  output logic [31:0]       inport0_rdata_o,
  output logic [1:0]        inport0_rresp_o,
  input  logic              inport1_awvalid_i,
  input  logic [ADDR_W-1:0] inport1_awaddr_i,
  input  logic              inport1_wvalid_i,
  input  logic [31:0]       inport1_wdata_i,
  input  logic [3:0]        inport1_wstrb_i,
  input  logic              inport1_bready_i,
  input  logic              inport1_arvalid_i,
  input  logic [ADDR_W-1:0] inport1_araddr_i,
  input  logic              inport1_rready_i,
  output logic              inport1_awready_o,
  output logic              inport1_wready_o,
  output logic              inport1_bvalid_o,
  output logic [1:0]        inport1_bresp_o,
  output logic              inport1_arready_o,
  output logic              inport1_rvalid_o,
  output logic [31:0]       inport1_rdata_o,
  output logic [1:0]        inport1_rresp_o,
  output logic              outport_awvalid_o,
  output logic [ADDR_W-1:0] outport_awaddr_o,
  output logic              outport_wvalid_o,
  output logic [31:0]       outport_wdata_o,
  output logic [3:0]        outport_wstrb_o,
  output logic              outport_bready_o,
  output logic              outport_arvalid_o,
  output logic [ADDR_W-1:0] outport_araddr_o,
  output logic              outport_rready_o,
  input  logic              outport_awready_i,
  input  logic              outport_wready_i,
  input  logic              outport_bvalid_i,
  input  logic [1:0]        outport_bresp_i,
  input  logic              outport_arready_i,
  input  logic              outport_rvalid_i,
  input  logic [31:0]       outport_rdata_i,
  input  logic [1:0]        outport_rresp_i
);

  typedef enum logic [2:0] {S_IDLE, S_WADDR, S_WRESP, S_READ, S_RRESP} state_t;

  state_t r_state;
  logic   r_grant, r_last, r_aw_done, r_w_done;

  logic w_req0, w_req1, w_pick, w_pick_wr;
  logic w_awvalid, w_wvalid, w_bready, w_arvalid, w_rready;
  logic w_awready, w_wready, w_bvalid, w_arready, w_rvalid;
  logic [1:0]  w_bresp, w_rresp;
  logic [31:0] w_rdata;
  logic w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;

  // Arbitration: a lone requester wins; on contention the port not served last
  assign w_req0    = inport0_awvalid_i | inport0_arvalid_i;
  assign w_req1    = inport1_awvalid_i | inport1_arvalid_i;
  assign w_pick    = (w_req0 & w_req1) ? ~r_last : w_req1;
  assign w_pick_wr = w_pick ? inport1_awvalid_i : inport0_awvalid_i;

  assign w_awvalid = r_grant ? inport1_awvalid_i : inport0_awvalid_i;
  assign w_wvalid  = r_grant ? inport1_wvalid_i  : inport0_wvalid_i;
  assign w_bready  = r_grant ? inport1_bready_i  : inport0_bready_i;
  assign w_arvalid = r_grant ? inport1_arvalid_i : inport0_arvalid_i;
  assign w_rready  = r_grant ? inport1_rready_i  : inport0_rready_i;

  assign outport_awaddr_o  = r_grant ? inport1_awaddr_i : inport0_awaddr_i;
  assign outport_wdata_o   = r_grant ? inport1_wdata_i  : inport0_wdata_i;
  assign outport_wstrb_o   = r_grant ? inport1_wstrb_i  : inport0_wstrb_i;
  assign outport_araddr_o  = r_grant ? inport1_araddr_i : inport0_araddr_i;

  // Done flags mask a channel once it has handshaken, so AW/W never repeat
  assign outport_awvalid_o = (r_state == S_WADDR) & w_awvalid & ~r_aw_done;
  assign outport_wvalid_o  = (r_state == S_WADDR) & w_wvalid  & ~r_w_done;
  assign outport_bready_o  = (r_state == S_WRESP) & w_bready;
  assign outport_arvalid_o = (r_state == S_READ)  & w_arvalid;
  assign outport_rready_o  = (r_state == S_RRESP) & w_rready;

  assign w_awready = (r_state == S_WADDR) & ~r_aw_done & outport_awready_i;
  assign w_wready  = (r_state == S_WADDR) & ~r_w_done  & outport_wready_i;
  assign w_bvalid  = (r_state == S_WRESP) & outport_bvalid_i;
  assign w_arready = (r_state == S_READ)  & outport_arready_i;
  assign w_rvalid  = (r_state == S_RRESP) & outport_rvalid_i;
  assign w_bresp   = (r_state == S_WRESP) ? outport_bresp_i : 2'b00;
  assign w_rdata   = (r_state == S_RRESP) ? outport_rdata_i : 32'h0;
  assign w_rresp   = (r_state == S_RRESP) ? outport_rresp_i : 2'b00;

  assign inport0_awready_o = ~r_grant & w_awready;
  assign inport0_wready_o  = ~r_grant & w_wready;
  assign inport0_bvalid_o  = ~r_grant & w_bvalid;
  assign inport0_arready_o = ~r_grant & w_arready;
  assign inport0_rvalid_o  = ~r_grant & w_rvalid;
  assign inport0_bresp_o   = r_grant ? 2'b00 : w_bresp;
  assign inport0_rdata_o   = r_grant ? 32'h0 : w_rdata;
  assign inport0_rresp_o   = r_grant ? 2'b00 : w_rresp;
  assign inport1_awready_o = r_grant & w_awready;
  assign inport1_wready_o  = r_grant & w_wready;
  assign inport1_bvalid_o  = r_grant & w_bvalid;
  assign inport1_arready_o = r_grant & w_arready;
  assign inport1_rvalid_o  = r_grant & w_rvalid;
  assign inport1_bresp_o   = r_grant ? w_bresp : 2'b00;
  assign inport1_rdata_o   = r_grant ? w_rdata : 32'h0;
  assign inport1_rresp_o   = r_grant ? w_rresp : 2'b00;

  assign w_aw_hs = outport_awvalid_o & outport_awready_i;
  assign w_w_hs  = outport_wvalid_o  & outport_wready_i;
  assign w_b_hs  = outport_bready_o  & outport_bvalid_i;
  assign w_ar_hs = outport_arvalid_o & outport_arready_i;
  assign w_r_hs  = outport_rready_o  & outport_rvalid_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state   <= S_IDLE;
      r_grant   <= 1'b0;
      r_last    <= 1'b1;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: if (w_req0 | w_req1) begin
          r_grant   <= w_pick;
          r_last    <= w_pick;
          r_aw_done <= 1'b0;
          r_w_done  <= 1'b0;
          r_state   <= w_pick_wr ? S_WADDR : S_READ;
        end
        S_WADDR: begin
          if (w_aw_hs) r_aw_done <= 1'b1;
          if (w_w_hs)  r_w_done  <= 1'b1;
          if ((r_aw_done | w_aw_hs) & (r_w_done | w_w_hs)) r_state <= S_WRESP;
        end
        S_WRESP: if (w_b_hs)  r_state <= S_IDLE;
        S_READ:  if (w_ar_hs) r_state <= S_RRESP;
        S_RRESP: if (w_r_hs)  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4lite_arb.sv
// Bench for axi4lite_arb: requester tasks per scenario, a responding slave
// model on the master port, and per-channel expectation queues.
module tb_axi4lite_arb;

  logic clk = 1'b0;
  logic rst_i = 1'b0;
  always #5 clk = ~clk;

  logic        awvalid[2], wvalid[2], bready[2], arvalid[2], rready[2];
  logic [31:0] awaddr[2], wdata[2], araddr[2];
  logic [3:0]  wstrb[2];
  logic        awready[2], wready[2], bvalid[2], arready[2], rvalid[2];
  logic [1:0]  bresp[2], rresp[2];
  logic [31:0] rdata[2];

  logic        o_awvalid, o_wvalid, o_bready, o_arvalid, o_rready;
  logic [31:0] o_awaddr, o_wdata, o_araddr;
  logic [3:0]  o_wstrb;
  logic        s_awready, s_wready, s_arready, s_bvalid, s_rvalid;
  logic [1:0]  s_bresp, s_rresp;
  logic [31:0] s_rdata;

  axi4lite_arb #(.ADDR_W(32)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .inport0_awvalid_i(awvalid[0]), .inport0_awaddr_i(awaddr[0]),
    .inport0_wvalid_i(wvalid[0]), .inport0_wdata_i(wdata[0]), .inport0_wstrb_i(wstrb[0]),
    .inport0_bready_i(bready[0]), .inport0_arvalid_i(arvalid[0]), .inport0_araddr_i(araddr[0]),
    .inport0_rready_i(rready[0]),
    .inport0_awready_o(awready[0]), .inport0_wready_o(wready[0]), .inport0_bvalid_o(bvalid[0]),
    .inport0_bresp_o(bresp[0]), .inport0_arready_o(arready[0]), .inport0_rvalid_o(rvalid[0]),
    .inport0_rdata_o(rdata[0]), .inport0_rresp_o(rresp[0]),
    .inport1_awvalid_i(awvalid[1]), .inport1_awaddr_i(awaddr[1]),
    .inport1_wvalid_i(wvalid[1]), .inport1_wdata_i(wdata[1]), .inport1_wstrb_i(wstrb[1]),
    .inport1_bready_i(bready[1]), .inport1_arvalid_i(arvalid[1]), .inport1_araddr_i(araddr[1]),
    .inport1_rready_i(rready[1]),
    .inport1_awready_o(awready[1]), .inport1_wready_o(wready[1]), .inport1_bvalid_o(bvalid[1]),
    .inport1_bresp_o(bresp[1]), .inport1_arready_o(arready[1]), .inport1_rvalid_o(rvalid[1]),
    .inport1_rdata_o(rdata[1]), .inport1_rresp_o(rresp[1]),
    .outport_awvalid_o(o_awvalid), .outport_awaddr_o(o_awaddr),
    .outport_wvalid_o(o_wvalid), .outport_wdata_o(o_wdata), .outport_wstrb_o(o_wstrb),
    .outport_bready_o(o_bready), .outport_arvalid_o(o_arvalid), .outport_araddr_o(o_araddr),
    .outport_rready_o(o_rready),
    .outport_awready_i(s_awready), .outport_wready_i(s_wready),
    .outport_bvalid_i(s_bvalid), .outport_bresp_i(s_bresp),
    .outport_arready_i(s_arready), .outport_rvalid_i(s_rvalid),
    .outport_rdata_i(s_rdata), .outport_rresp_i(s_rresp)
  );

  wire [14:0] all_vr = {o_awvalid, o_wvalid, o_bready, o_arvalid, o_rready,
                        awready[0], wready[0], arready[0], bvalid[0], rvalid[0],
                        awready[1], wready[1], arready[1], bvalid[1], rvalid[1]};

  // Slave: B once both AW and W landed (bresp = awaddr[1:0]); R one cycle after
  // AR with halves of the address swapped (rresp = araddr[1:0]).
  logic        s_aw, s_w;
  logic [1:0]  s_baddr;
  wire s_aw_hs = o_awvalid & s_awready;
  wire s_w_hs  = o_wvalid & s_wready;
  wire s_aw_n  = s_aw | s_aw_hs;
  wire s_w_n   = s_w | s_w_hs;
  always @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      s_aw <= 1'b0; s_w <= 1'b0; s_baddr <= 2'b00;
      s_bvalid <= 1'b0; s_bresp <= 2'b00;
      s_rvalid <= 1'b0; s_rdata <= 32'h0; s_rresp <= 2'b00;
    end else begin
      if (s_aw_hs) s_baddr <= o_awaddr[1:0];
      if (s_bvalid && o_bready) s_bvalid <= 1'b0;
      if (s_aw_n && s_w_n) begin
        s_bvalid <= 1'b1;
        s_bresp  <= s_aw_hs ? o_awaddr[1:0] : s_baddr;
        s_aw <= 1'b0; s_w <= 1'b0;
      end else begin
        s_aw <= s_aw_n; s_w <= s_w_n;
      end
      if (o_arvalid && s_arready) begin
        s_rvalid <= 1'b1;
        s_rdata  <= {o_araddr[15:0], o_araddr[31:16]};
        s_rresp  <= o_araddr[1:0];
      end else if (s_rvalid && o_rready) s_rvalid <= 1'b0;
    end
  end

  int total = 0;
  int bad = 0;
  int cyc_cnt = 0;
  int ar_cyc = 0, b0_cyc = 0, aw_hs_n = 0, w_hs_n = 0;
  logic [31:0] q_ar[$];
  logic [31:0] q_aw[$];
  logic [35:0] q_w[$];
  logic [33:0] q_r0[$], q_r1[$];
  logic [1:0]  q_b0[$], q_b1[$];
  logic [35:0] m_exp;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Scoreboard: pop and compare whenever a handshake is about to complete
  always @(negedge clk) if (rst_i) begin
    if (o_arvalid && s_arready) begin
      total++; ar_cyc = cyc_cnt;
      if (q_ar.size() == 0) begin bad++; $display("FAIL ar_order got=%h required=none", o_araddr); end
      else begin m_exp = {4'h0, q_ar.pop_front()};
        if (o_araddr !== m_exp[31:0]) begin bad++; $display("FAIL ar_order got=%h required=%h", o_araddr, m_exp[31:0]); end
      end
    end
    if (o_awvalid && s_awready) begin
      total++; aw_hs_n++;
      if (q_aw.size() == 0) begin bad++; $display("FAIL awaddr got=%h required=none", o_awaddr); end
      else begin m_exp = {4'h0, q_aw.pop_front()};
        if (o_awaddr !== m_exp[31:0]) begin bad++; $display("FAIL awaddr got=%h required=%h", o_awaddr, m_exp[31:0]); end
      end
    end
    if (o_wvalid && s_wready) begin
      total++; w_hs_n++;
      if (q_w.size() == 0) begin bad++; $display("FAIL wdata got=%h required=none", {o_wdata, o_wstrb}); end
      else begin m_exp = q_w.pop_front();
        if ({o_wdata, o_wstrb} !== m_exp) begin bad++; $display("FAIL wdata got=%h required=%h", {o_wdata, o_wstrb}, m_exp); end
      end
    end
    if (rvalid[0] && rready[0]) begin
      total++;
      if (q_r0.size() == 0) begin bad++; $display("FAIL rdata0 got=%h required=none", rdata[0]); end
      else begin m_exp = {2'b00, q_r0.pop_front()};
        if ({rdata[0], rresp[0]} !== m_exp[33:0]) begin bad++; $display("FAIL rdata0 got=%h required=%h", {rdata[0], rresp[0]}, m_exp[33:0]); end
      end
    end
    if (rvalid[1] && rready[1]) begin
      total++;
      if (q_r1.size() == 0) begin bad++; $display("FAIL rdata1 got=%h required=none", rdata[1]); end
      else begin m_exp = {2'b00, q_r1.pop_front()};
        if ({rdata[1], rresp[1]} !== m_exp[33:0]) begin bad++; $display("FAIL rdata1 got=%h required=%h", {rdata[1], rresp[1]}, m_exp[33:0]); end
      end
    end
    if (bvalid[0] && bready[0]) begin
      total++; b0_cyc = cyc_cnt;
      if (q_b0.size() == 0) begin bad++; $display("FAIL bresp0 got=%h required=none", bresp[0]); end
      else begin m_exp = {34'h0, q_b0.pop_front()};
        if (bresp[0] !== m_exp[1:0]) begin bad++; $display("FAIL bresp0 got=%h required=%h", bresp[0], m_exp[1:0]); end
      end
    end
    if (bvalid[1] && bready[1]) begin
      total++;
      if (q_b1.size() == 0) begin bad++; $display("FAIL bresp1 got=%h required=none", bresp[1]); end
      else begin m_exp = {34'h0, q_b1.pop_front()};
        if (bresp[1] !== m_exp[1:0]) begin bad++; $display("FAIL bresp1 got=%h required=%h", bresp[1], m_exp[1:0]); end
      end
    end
  end

  // Tasks start and end just after a rising edge; handshake cycles are
  // reported relative to the first cycle the request is visible.
  task automatic do_write(input int p, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input int w_dly,
                          output int aw_c, output int w_c, output int b_c);
    int cyc = 0;
    bit done = 0;
    bit ah, wh, bh;
    q_aw.push_back(a);
    q_w.push_back({d, s});
    if (p == 0) q_b0.push_back(a[1:0]); else q_b1.push_back(a[1:0]);
    awaddr[p] = a; wdata[p] = d; wstrb[p] = s;
    awvalid[p] = 1'b1; wvalid[p] = (w_dly == 0); bready[p] = 1'b1;
    aw_c = -1; w_c = -1; b_c = -1;
    while (!done && cyc < 100) begin
      @(negedge clk);
      ah = awvalid[p] && awready[p];
      wh = wvalid[p] && wready[p];
      bh = bvalid[p] && bready[p];
      if (ah) aw_c = cyc;
      if (wh) w_c = cyc;
      if (bh) b_c = cyc;
      @(posedge clk); #1; cyc++;
      if (ah) awvalid[p] = 1'b0;
      if (wh) wvalid[p] = 1'b0;
      if (bh) begin bready[p] = 1'b0; done = 1; end
      if (cyc == w_dly && w_c < 0) wvalid[p] = 1'b1;
    end
    total++;
    if (!done) begin
      bad++; $display("FAIL write_timeout port=%0d got=incomplete required=complete", p);
      awvalid[p] = 1'b0; wvalid[p] = 1'b0; bready[p] = 1'b0;
    end
  endtask

  task automatic do_read(input int p, input logic [31:0] a, input int r_dly);
    int cyc = 0;
    int rv = 0;
    bit done = 0;
    bit ah, rh;
    if (p == 0) q_r0.push_back({a[15:0], a[31:16], a[1:0]});
    else        q_r1.push_back({a[15:0], a[31:16], a[1:0]});
    araddr[p] = a; arvalid[p] = 1'b1; rready[p] = (r_dly == 0);
    while (!done && cyc < 100) begin
      @(negedge clk);
      ah = arvalid[p] && arready[p];
      rh = rvalid[p] && rready[p];
      if (rvalid[p] && !rready[p]) rv++;
      @(posedge clk); #1; cyc++;
      if (ah) arvalid[p] = 1'b0;
      if (rh) begin rready[p] = 1'b0; done = 1; end
      else if (rv >= r_dly) rready[p] = 1'b1;
    end
    total++;
    if (!done) begin
      bad++; $display("FAIL read_timeout port=%0d got=incomplete required=complete", p);
      arvalid[p] = 1'b0; rready[p] = 1'b0;
    end
  endtask

  task automatic test_reset();
    awvalid[0] = 1'b1; wvalid[0] = 1'b1; arvalid[1] = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (all_vr !== 15'h0) begin bad++; $display("FAIL reset_vr got=%h required=0", all_vr); end
    total++;
    if ({rdata[0], rdata[1], rresp[0], rresp[1], bresp[0], bresp[1]} !== 72'h0) begin
      bad++; $display("FAIL reset_data got=%h required=0", {rdata[0], rdata[1], rresp[0], rresp[1], bresp[0], bresp[1]});
    end
    awvalid[0] = 1'b0; wvalid[0] = 1'b0; arvalid[1] = 1'b0;
    rst_i = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (all_vr !== 15'h0) begin bad++; $display("FAIL idle_vr got=%h required=0", all_vr); end
    @(posedge clk); #1;
  endtask

  task automatic test_single_write();
    int aw_c, w_c, b_c, aw0, w0;
    bit p1_ok = 1;
    aw0 = aw_hs_n; w0 = w_hs_n;
    fork
      do_write(0, 32'h9200_0000, 32'h0000_00A5, 4'hF, 0, aw_c, w_c, b_c);
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        if ({awready[1], wready[1], bvalid[1], arready[1], rvalid[1], bresp[1], rresp[1], rdata[1]} !== 41'h0) p1_ok = 0;
      end
    join
    total++;
    if (!p1_ok) begin bad++; $display("FAIL single_port1_quiet got=active required=0"); end
    total++;
    if ({aw_c, w_c, b_c} !== {32'd1, 32'd1, 32'd2}) begin
      bad++; $display("FAIL single_timing got=aw%0d/w%0d/b%0d required=aw1/w1/b2", aw_c, w_c, b_c);
    end
    total++;
    if ((aw_hs_n - aw0) !== 1 || (w_hs_n - w0) !== 1) begin
      bad++; $display("FAIL single_hs_count got=aw%0d/w%0d required=1/1", aw_hs_n - aw0, w_hs_n - w0);
    end
  endtask

  task automatic test_contention();
    rst_i = 1'b0;
    @(posedge clk); #1;
    rst_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      q_ar.push_back(32'h1000_0000 + (i << 8) + i);
      q_ar.push_back(32'h2000_0000 + (i << 8) + (3 - i));
    end
    fork
      for (int i = 0; i < 4; i++) do_read(0, 32'h1000_0000 + (i << 8) + i, 0);
      for (int j = 0; j < 4; j++) do_read(1, 32'h2000_0000 + (j << 8) + (3 - j), 0);
    join
  endtask

  task automatic test_aw_before_w();
    int aw_c, w_c, b_c, aw0, w0;
    aw0 = aw_hs_n; w0 = w_hs_n;
    do_write(1, 32'h5000_0002, 32'hCAFE_0001, 4'hC, 3, aw_c, w_c, b_c);
    total++;
    if ({aw_c, w_c, b_c} !== {32'd1, 32'd3, 32'd4}) begin
      bad++; $display("FAIL aw_before_w_timing got=aw%0d/w%0d/b%0d required=aw1/w3/b4", aw_c, w_c, b_c);
    end
    total++;
    if ((aw_hs_n - aw0) !== 1 || (w_hs_n - w0) !== 1) begin
      bad++; $display("FAIL aw_before_w_hs_count got=aw%0d/w%0d required=1/1", aw_hs_n - aw0, w_hs_n - w0);
    end
  endtask

  task automatic test_backpressure();
    q_ar.push_back(32'hBEEF_DEAD);
    q_ar.push_back(32'h3000_0002);
    fork
      do_read(0, 32'hBEEF_DEAD, 5);
      begin @(posedge clk); #1; do_read(1, 32'h3000_0002, 0); end
      begin
        int n = 0;
        do begin @(negedge clk); n++; end while (!rvalid[0] && n < 50);
        for (int k = 0; k < 5; k++) begin
          if (k > 0) @(negedge clk);
          total++;
          if ({rvalid[0], rdata[0], o_rready, o_arvalid, arready[1]} !== {1'b1, 32'hDEAD_BEEF, 3'b000}) begin
            bad++; $display("FAIL backpressure k=%0d got=%h required=%h", k,
              {rvalid[0], rdata[0], o_rready, o_arvalid, arready[1]}, {1'b1, 32'hDEAD_BEEF, 3'b000});
          end
        end
      end
    join
  endtask

  task automatic test_rw_same_port();
    int aw_c, w_c, b_c;
    q_ar.push_back(32'h4000_0100);
    fork
      do_write(0, 32'h4000_0001, 32'h1234_5678, 4'h3, 0, aw_c, w_c, b_c);
      do_read(0, 32'h4000_0100, 0);
    join
    total++;
    if (ar_cyc !== b0_cyc + 2) begin
      bad++; $display("FAIL rw_order got=ar@%0d required=ar@%0d", ar_cyc, b0_cyc + 2);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    q_aw.push_back(32'h6000_0000);
    q_w.push_back({32'h0000_0077, 4'hF});
    awaddr[0] = 32'h6000_0000; wdata[0] = 32'h0000_0077; wstrb[0] = 4'hF;
    awvalid[0] = 1'b1; wvalid[0] = 1'b1; bready[0] = 1'b0;
    do begin @(negedge clk); n++; end while (!bvalid[0] && n < 20);
    total++;
    if (bvalid[0] !== 1'b1) begin bad++; $display("FAIL reset_mid_wresp got=%b required=1", bvalid[0]); end
    #2 rst_i = 1'b0;
    #1;
    total++;
    if (all_vr !== 15'h0) begin bad++; $display("FAIL reset_mid_vr got=%h required=0", all_vr); end
    awvalid[0] = 1'b0; wvalid[0] = 1'b0;
    @(negedge clk);
    rst_i = 1'b1;
    @(posedge clk); #1;
    q_ar.push_back(32'h7000_0000);
    q_ar.push_back(32'h7100_0001);
    fork
      do_read(1, 32'h7100_0001, 0);
      do_read(0, 32'h7000_0000, 0);
    join
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int p = 0; p < 2; p++) begin
      awvalid[p] = 1'b0; wvalid[p] = 1'b0; bready[p] = 1'b0; arvalid[p] = 1'b0; rready[p] = 1'b0;
      awaddr[p] = 32'h0; wdata[p] = 32'h0; wstrb[p] = 4'h0; araddr[p] = 32'h0;
    end
    s_awready = 1'b1; s_wready = 1'b1; s_arready = 1'b1;
    test_reset();
    test_single_write();
    test_contention();
    test_aw_before_w();
    test_backpressure();
    test_rw_same_port();
    test_reset_mid();
    repeat (2) @(posedge clk);
    total++;
    if (q_ar.size() + q_aw.size() + q_w.size() + q_r0.size() + q_r1.size() + q_b0.size() + q_b1.size() != 0) begin
      bad++; $display("FAIL leftover_expect got=%0d required=0",
        q_ar.size() + q_aw.size() + q_w.size() + q_r0.size() + q_r1.size() + q_b0.size() + q_b1.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
